flex_down_counter: RTL and testbench

Loadable down-counter/timer for the JTAG block. It is the counting-down counterpart of the team's flexible up-counter. It is loaded with a start value, decrements on each enabled cycle, and signals expiry at the terminal count. It supports one-shot and auto-reload modes, so it can generate shift-length countdowns and periodic ticks for the TAP-side control logic.

---
 rtl/flex_down_counter.sv | 96 +++++++++
 tb/tb_flex_down_counter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/flex_down_counter.sv
// Loadable down-counter/timer with one-shot and auto-reload modes.
// expire pulses for one cycle after a terminal decrement; done/busy decode the registered state.
module flex_down_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    input  logic                    reload_en,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    expire,
    output logic                    done,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1);

    state_t                  state_q,  state_d;
    logic [NUM_CNT_BITS-1:0] count_q,  count_d;
    logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
    logic                    expire_q, expire_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= CNT_ZERO;
            reload_q <= CNT_ZERO;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            expire_q <= expire_d;
        end
    end

    // Priority: clear > load > counting; count never decrements from 0 since RUN implies nonzero.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        expire_d = 1'b0;
        if (clear) begin
            state_d = IDLE;
            count_d = CNT_ZERO;
        end else if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = (load_val != CNT_ZERO) ? RUN : EXPIRED;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (count_enable) begin
                        if (count_q == CNT_ONE) begin
                            expire_d = 1'b1;
                            if (reload_en) begin
                                count_d = reload_q;
                            end else begin
                                count_d = CNT_ZERO;
                                state_d = EXPIRED;
                            end
                        end else begin
                            count_d = count_q - CNT_ONE;
                        end
                    end
                end
                IDLE, EXPIRED: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = IDLE;
                    count_d = CNT_ZERO;
                end
            endcase
        end
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == EXPIRED);
    end

    assign count_out = count_q;
    assign expire    = expire_q;

endmodule

// File: tb/tb_flex_down_counter.sv
// Scoreboard bench for flex_down_counter: directed scenarios followed by random traffic,
// expected outputs come from a behavioural timer model and are checked by a separate monitor.
module tb_flex_down_counter;

    logic       clk = 1'b0;
    logic       rst, clear, load, count_enable, reload_en;
    logic [3:0] load_val;
    logic [3:0] count_out;
    logic       expire, done, busy;

    typedef struct {
        logic [3:0] cnt;
        logic       exp;
        logic       dn;
        logic       bsy;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    string cur_tag = "init";

    // Behavioural timer: remaining ticks, period, whether the timer is armed or has finished.
    int m_remaining = 0;
    int m_period    = 0;
    bit m_armed     = 0;
    bit m_finished  = 0;

    flex_down_counter #(.NUM_CNT_BITS(4)) dut (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
        .count_enable(count_enable), .reload_en(reload_en),
        .count_out(count_out), .expire(expire), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step(input bit r, input bit c, input bit l, input int v,
                        input bit e, input bit rl);
        exp_t x;
        bit   pulse;
        @(negedge clk);
        rst = r; clear = c; load = l; load_val = 4'(v); count_enable = e; reload_en = rl;
        pulse = 0;
        if (r) begin
            m_remaining = 0; m_period = 0; m_armed = 0; m_finished = 0;
        end else if (c) begin
            m_remaining = 0; m_armed = 0; m_finished = 0;
        end else if (l) begin
            m_period    = v;
            m_remaining = v;
            m_armed     = (v != 0);
            m_finished  = (v == 0);
        end else if (m_armed && e) begin
            m_remaining = m_remaining - 1;
            if (m_remaining == 0) begin
                pulse = 1;
                if (rl) m_remaining = m_period;
                else begin
                    m_armed = 0; m_finished = 1;
                end
            end
        end
        x.cnt = 4'(m_remaining);
        x.exp = pulse;
        x.dn  = m_finished;
        x.bsy = m_armed;
        x.tag = cur_tag;
        q.push_back(x);
    endtask

    task automatic idle_step(input bit e, input bit rl);
        step(0, 0, 0, 0, e, rl);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            checks++;
            if (count_out !== x.cnt || expire !== x.exp || done !== x.dn || busy !== x.bsy) begin
                errors++;
                $display("FAIL %s t=%0t: got cnt=%0d expire=%b done=%b busy=%b, want cnt=%0d expire=%b done=%b busy=%b",
                         x.tag, $time, count_out, expire, done, busy, x.cnt, x.exp, x.dn, x.bsy);
            end
        end
    end

    initial begin
        rst = 1; clear = 0; load = 0; load_val = 0; count_enable = 0; reload_en = 0;

        cur_tag = "reset";
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 9, 1, 1);

        cur_tag = "idle_no_load";
        repeat (4) idle_step(1, 0);

        cur_tag = "one_shot_5";
        step(0, 0, 1, 5, 1, 0);
        repeat (7) idle_step(1, 0);

        cur_tag = "auto_reload_3";
        step(0, 0, 1, 3, 1, 1);
        repeat (10) idle_step(1, 1);

        cur_tag = "auto_reload_1";
        step(0, 0, 1, 1, 1, 1);
        repeat (4) idle_step(1, 1);

        cur_tag = "enable_gating";
        step(0, 0, 1, 4, 0, 0);
        idle_step(1, 0); idle_step(0, 0); idle_step(0, 0);
        idle_step(1, 0); idle_step(1, 0); idle_step(1, 0);
        idle_step(1, 0);

        cur_tag = "load_on_terminal";
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 7, 1, 0);
        repeat (2) idle_step(1, 0);

        cur_tag = "clear_on_terminal";
        step(0, 0, 1, 1, 0, 1);
        step(0, 1, 0, 0, 1, 1);
        repeat (2) idle_step(1, 0);

        cur_tag = "load_zero";
        step(0, 0, 1, 0, 1, 0);
        repeat (2) idle_step(1, 1);

        cur_tag = "rst_mid_run";
        step(0, 0, 1, 5, 1, 0);
        repeat (3) idle_step(1, 0);
        step(1, 0, 1, 6, 1, 1);
        idle_step(1, 0);

        cur_tag = "max_load_15";
        step(0, 0, 1, 15, 1, 0);
        repeat (16) idle_step(1, 0);

        cur_tag = "random";
        for (int i = 0; i < 600; i++) begin
            bit r, c, l, e, rl;
            r  = ($urandom_range(0, 79) == 0);
            c  = ($urandom_range(0, 24) == 0);
            l  = ($urandom_range(0, 9) == 0);
            e  = ($urandom_range(0, 9) < 7);
            rl = $urandom_range(0, 1);
            step(r, c, l, $urandom_range(0, 15), e, rl);
        end

        idle_step(0, 0);
        // Let the monitor drain the final expectations, bounded.
        for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
